// File: rtl/nv_nvdla_part_pkg.sv
// Shared definitions for the partition read arbiter: request payload layout,
// size-field width and the arbitration mode encoding.
package nv_nvdla_part_pkg;

  // Burst size is carried as beats-1 in a fixed-width field above the address
  localparam int SIZE_W = 15;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // The size field sits directly above the address in the request payload
  function automatic int pd_size_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int pd_width(input int addr_w);
    return addr_w + SIZE_W;
  endfunction

endpackage

// File: rtl/nv_nvdla_part_tag_fifo.sv
// Flop-based tag FIFO recording {channel, size} for every outstanding read.
// Full/empty come from the occupancy before this cycle's update, so a push
// and a pop in the same cycle leave the occupancy unchanged.
module nv_nvdla_part_tag_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/nv_nvdla_part_rd_arb.sv
// Read-request arbiter for one partition: merges per-channel read requests
// into a single MCIF request stream (round-robin or fixed priority) and
// routes the in-order responses back to the issuing channel via a tag FIFO.
module nv_nvdla_part_rd_arb
  import nv_nvdla_part_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int ADDR_W    = 32,
  parameter int RSP_W     = 65,
  parameter int TAG_DEPTH = 8
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rstn,
  input  logic                          arb_mode,
  input  logic [NUM_CH-1:0]             ch_req_valid,
  output logic [NUM_CH-1:0]             ch_req_ready,
  input  logic [NUM_CH*(ADDR_W+15)-1:0] ch_req_pd,
  output logic                          mc_req_valid,
  input  logic                          mc_req_ready,
  output logic [ADDR_W+14:0]            mc_req_pd,
  input  logic                          mc_rsp_valid,
  output logic                          mc_rsp_ready,
  input  logic [RSP_W-1:0]              mc_rsp_pd,
  output logic [NUM_CH-1:0]             ch_rsp_valid,
  input  logic [NUM_CH-1:0]             ch_rsp_ready,
  output logic [RSP_W-1:0]              ch_rsp_pd,
  output logic [NUM_CH-1:0]             ch_cdt_lat_fifo_pop,
  output logic                          rsp_orphan_err
);

  localparam int PD_W     = pd_width(ADDR_W);
  localparam int SIZE_LSB = pd_size_lsb(ADDR_W);
  localparam int CH_W     = $clog2(NUM_CH);
  localparam int TAG_W    = CH_W + SIZE_W;

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   sel_ch;
  logic              sel_found;
  logic [PD_W-1:0]   sel_pd;
  logic              can_arb;
  logic              grant;
  logic              out_valid;
  logic [PD_W-1:0]   out_pd;
  logic              tag_full;
  logic              tag_empty;
  logic [TAG_W-1:0]  tag_rdata;
  logic [CH_W-1:0]   head_ch;
  logic [SIZE_W-1:0] head_size;
  logic [SIZE_W-1:0] beat_cnt;
  logic              beat;
  logic              tag_pop;
  logic [NUM_CH-1:0] cdt_pop_q;
  logic              orphan_q;

  // Arbitrate only when the output stage can take a new request and a tag
  // slot is free; reset gates the grant so no ready leaks out during reset
  assign can_arb = (~out_valid | mc_req_ready) & ~tag_full & nvdla_core_rstn;
  assign grant   = can_arb & sel_found;

  // Winner selection: RR searches above the last grant then wraps to the
  // lowest index; fixed mode is just the wrap-around pass
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    if (arb_mode != ARB_FIXED) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!sel_found && ch_req_valid[i] && (CH_W'(i) > rr_ptr)) begin
          sel_found = 1'b1;
          sel_ch    = CH_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!sel_found && ch_req_valid[i]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(i);
      end
    end
  end

  // Ready goes only to the winner and the winner's payload is muxed forward
  always_comb begin
    sel_pd       = '0;
    ch_req_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ch == CH_W'(i)) begin
        sel_pd          = ch_req_pd[i*PD_W +: PD_W];
        ch_req_ready[i] = grant;
      end
    end
  end

  // Output stage reloads whenever it is empty or being consumed, which also
  // drains it when the tag FIFO is full; otherwise it holds for backpressure
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_valid <= 1'b0;
      out_pd    <= '0;
    end else if (!out_valid || mc_req_ready) begin
      out_valid <= grant;
      out_pd    <= sel_pd;
    end
  end

  // Round-robin pointer tracks the last accepted grant in RR mode only
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rr_ptr <= CH_W'(NUM_CH - 1);
    end else if (grant && (arb_mode != ARB_FIXED)) begin
      rr_ptr <= sel_ch;
    end
  end

  assign mc_req_valid = out_valid;
  assign mc_req_pd    = out_pd;

  nv_nvdla_part_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (nvdla_core_clk),
    .rst_n (nvdla_core_rstn),
    .push  (grant),
    .wdata ({sel_ch, sel_pd[SIZE_LSB +: SIZE_W]}),
    .pop   (tag_pop),
    .rdata (tag_rdata),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign head_ch   = tag_rdata[TAG_W-1 -: CH_W];
  assign head_size = tag_rdata[SIZE_W-1:0];
  assign ch_rsp_pd = mc_rsp_pd;

  // Responses are routed to the head tag's channel; with no tag outstanding
  // nothing is routed and the response is refused
  always_comb begin
    ch_rsp_valid = '0;
    mc_rsp_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (head_ch == CH_W'(i)) begin
        ch_rsp_valid[i] = mc_rsp_valid & ~tag_empty;
        mc_rsp_ready    = ch_rsp_ready[i] & ~tag_empty;
      end
    end
  end

  assign beat    = mc_rsp_valid & mc_rsp_ready;
  assign tag_pop = beat & (beat_cnt == head_size);

  // Beat counter for the head tag; the final beat retires the tag
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      beat_cnt <= '0;
    end else if (tag_pop) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Credit-return pulse per accepted beat, and the sticky orphan flag
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cdt_pop_q <= '0;
      orphan_q  <= 1'b0;
    end else begin
      cdt_pop_q <= ch_rsp_valid & ch_rsp_ready;
      if (mc_rsp_valid && tag_empty) orphan_q <= 1'b1;
    end
  end

  assign ch_cdt_lat_fifo_pop = cdt_pop_q;
  assign rsp_orphan_err      = orphan_q;

endmodule

// File: tb/tb_nv_nvdla_part_rd_arb.sv
// Directed self-checking bench for the partition read arbiter.
module tb_nv_nvdla_part_rd_arb;

  localparam int NUM_CH    = 3;
  localparam int ADDR_W    = 32;
  localparam int RSP_W     = 65;
  localparam int TAG_DEPTH = 8;
  localparam int PD_W      = ADDR_W + 15;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   arb_mode;
  logic [NUM_CH-1:0]      ch_req_valid;
  logic [NUM_CH-1:0]      ch_req_ready;
  logic [NUM_CH*PD_W-1:0] ch_req_pd;
  logic                   mc_req_valid;
  logic                   mc_req_ready;
  logic [PD_W-1:0]        mc_req_pd;
  logic                   mc_rsp_valid;
  logic                   mc_rsp_ready;
  logic [RSP_W-1:0]       mc_rsp_pd;
  logic [NUM_CH-1:0]      ch_rsp_valid;
  logic [NUM_CH-1:0]      ch_rsp_ready;
  logic [RSP_W-1:0]       ch_rsp_pd;
  logic [NUM_CH-1:0]      ch_cdt_lat_fifo_pop;
  logic                   rsp_orphan_err;

  int checks = 0;
  int errors = 0;
  int popTotal;

  always #5 clk = ~clk;

  nv_nvdla_part_rd_arb #(
    .NUM_CH    (NUM_CH),
    .ADDR_W    (ADDR_W),
    .RSP_W     (RSP_W),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rstn),
    .arb_mode            (arb_mode),
    .ch_req_valid        (ch_req_valid),
    .ch_req_ready        (ch_req_ready),
    .ch_req_pd           (ch_req_pd),
    .mc_req_valid        (mc_req_valid),
    .mc_req_ready        (mc_req_ready),
    .mc_req_pd           (mc_req_pd),
    .mc_rsp_valid        (mc_rsp_valid),
    .mc_rsp_ready        (mc_rsp_ready),
    .mc_rsp_pd           (mc_rsp_pd),
    .ch_rsp_valid        (ch_rsp_valid),
    .ch_rsp_ready        (ch_rsp_ready),
    .ch_rsp_pd           (ch_rsp_pd),
    .ch_cdt_lat_fifo_pop (ch_cdt_lat_fifo_pop),
    .rsp_orphan_err      (rsp_orphan_err)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Request payload for a channel: distinct address per channel plus size
  function automatic logic [PD_W-1:0] pdOf(input int ch, input int size);
    return {15'(size), 32'h1000_0000 + 32'(ch * 16)};
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] valid, input int s0, input int s1, input int s2);
    ch_req_valid = valid;
    ch_req_pd    = {pdOf(2, s2), pdOf(1, s1), pdOf(0, s0)};
  endtask

  task automatic applyReset();
    rstn         = 1'b0;
    arb_mode     = 1'b0;
    mc_req_ready = 1'b0;
    mc_rsp_valid = 1'b0;
    mc_rsp_pd    = '0;
    ch_rsp_ready = '0;
    applyStimulus('0, 0, 0, 0);
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn         = 1'b0;
    arb_mode     = 1'b0;
    mc_req_ready = 1'b0;
    mc_rsp_valid = 1'b0;
    mc_rsp_pd    = '0;
    ch_rsp_ready = '0;
    applyStimulus('0, 0, 0, 0);
    #2;
    checkOutput("rst_ch_req_ready", ch_req_ready, 0);
    checkOutput("rst_mc_req_valid", mc_req_valid, 0);
    checkOutput("rst_ch_rsp_valid", ch_rsp_valid, 0);
    checkOutput("rst_cdt_pop", ch_cdt_lat_fifo_pop, 0);
    checkOutput("rst_orphan", rsp_orphan_err, 0);

    // Round-robin, all channels valid, MCIF always ready
    applyReset();
    mc_req_ready = 1'b1;
    applyStimulus(3'b111, 0, 0, 0);
    #1;
    checkOutput("rr_mc_valid_pre", mc_req_valid, 0);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("rr_ready_%0d", k), ch_req_ready, 3'b001 << (k % 3));
      tick();
      checkOutput($sformatf("rr_mc_valid_%0d", k), mc_req_valid, 1);
      checkOutput($sformatf("rr_mc_pd_%0d", k), mc_req_pd, pdOf(k % 3, 0));
    end

    // Fixed priority: ch0 wins while valid, backpressure holds the request
    applyReset();
    arb_mode     = 1'b1;
    mc_req_ready = 1'b1;
    applyStimulus(3'b101, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("fix_ready_%0d", k), ch_req_ready, 3'b001);
      tick();
      checkOutput($sformatf("fix_pd_%0d", k), mc_req_pd, pdOf(0, 0));
    end
    mc_req_ready = 1'b0;
    #1;
    checkOutput("fix_stall_ready", ch_req_ready, 3'b000);
    tick();
    checkOutput("fix_hold_valid", mc_req_valid, 1);
    checkOutput("fix_hold_pd", mc_req_pd, pdOf(0, 0));
    mc_req_ready = 1'b1;
    applyStimulus(3'b100, 0, 0, 0);
    #1;
    checkOutput("fix_ch2_ready", ch_req_ready, 3'b100);
    tick();
    checkOutput("fix_ch2_pd", mc_req_pd, pdOf(2, 0));

    // Tag FIFO full: eight requests accepted, the ninth waits for a pop
    applyReset();
    mc_req_ready = 1'b1;
    applyStimulus(3'b001, 0, 0, 0);
    for (int k = 0; k < TAG_DEPTH; k++) begin
      #1;
      checkOutput($sformatf("full_ready_%0d", k), ch_req_ready, 3'b001);
      tick();
    end
    #1;
    checkOutput("full_stall", ch_req_ready, 3'b000);
    tick();
    checkOutput("full_stall2", ch_req_ready, 3'b000);
    checkOutput("full_mc_drained", mc_req_valid, 0);
    mc_rsp_valid = 1'b1;
    ch_rsp_ready = 3'b111;
    mc_rsp_pd    = 65'h5;
    #1;
    checkOutput("full_rsp_route", ch_rsp_valid, 3'b001);
    checkOutput("full_rsp_ready", mc_rsp_ready, 1);
    checkOutput("full_still_stall", ch_req_ready, 3'b000);
    tick();
    mc_rsp_valid = 1'b0;
    #1;
    checkOutput("full_resume", ch_req_ready, 3'b001);
    checkOutput("full_cdt_pop", ch_cdt_lat_fifo_pop, 3'b001);

    // Multi-beat routing: ch1 size 3, then ch0 size 0
    applyReset();
    mc_req_ready = 1'b1;
    applyStimulus(3'b010, 0, 3, 0);
    #1;
    checkOutput("mb_ready_ch1", ch_req_ready, 3'b010);
    tick();
    applyStimulus(3'b001, 0, 0, 0);
    #1;
    checkOutput("mb_ready_ch0", ch_req_ready, 3'b001);
    checkOutput("mb_pd_ch1", mc_req_pd, pdOf(1, 3));
    tick();
    checkOutput("mb_pd_ch0", mc_req_pd, pdOf(0, 0));
    applyStimulus(3'b000, 0, 0, 0);
    ch_rsp_ready = 3'b111;
    mc_rsp_valid = 1'b1;
    popTotal     = 0;
    for (int b = 0; b < 5; b++) begin
      mc_rsp_pd = 65'(b + 256);
      #1;
      checkOutput($sformatf("mb_route_%0d", b), ch_rsp_valid, (b < 4) ? 3'b010 : 3'b001);
      checkOutput($sformatf("mb_rsp_pd_%0d", b), ch_rsp_pd, 65'(b + 256));
      tick();
      checkOutput($sformatf("mb_cdt_%0d", b), ch_cdt_lat_fifo_pop, (b < 4) ? 3'b010 : 3'b001);
      popTotal += $countones(ch_cdt_lat_fifo_pop);
    end
    mc_rsp_valid = 1'b0;
    tick();
    checkOutput("mb_cdt_idle", ch_cdt_lat_fifo_pop, 3'b000);
    checkOutput("mb_cdt_total", 96'(popTotal), 5);

    // Orphan response with no outstanding tag
    mc_rsp_valid = 1'b1;
    #1;
    checkOutput("orph_rsp_ready", mc_rsp_ready, 0);
    checkOutput("orph_route", ch_rsp_valid, 3'b000);
    checkOutput("orph_not_yet", rsp_orphan_err, 0);
    tick();
    checkOutput("orph_set", rsp_orphan_err, 1);
    mc_rsp_valid = 1'b0;
    repeat (3) tick();
    checkOutput("orph_sticky", rsp_orphan_err, 1);

    // Asynchronous reset with three tags outstanding
    applyReset();
    checkOutput("orph_cleared", rsp_orphan_err, 0);
    mc_req_ready = 1'b1;
    applyStimulus(3'b111, 0, 0, 0);
    repeat (3) tick();
    mc_rsp_valid = 1'b1;
    ch_rsp_ready = 3'b111;
    #1;
    checkOutput("ar_pre_mc_valid", mc_req_valid, 1);
    checkOutput("ar_pre_route", ch_rsp_valid, 3'b001);
    checkOutput("ar_pre_ready", ch_req_ready, 3'b001);
    rstn = 1'b0;
    #1;
    checkOutput("ar_ch_req_ready", ch_req_ready, 3'b000);
    checkOutput("ar_mc_req_valid", mc_req_valid, 0);
    checkOutput("ar_ch_rsp_valid", ch_rsp_valid, 3'b000);
    checkOutput("ar_mc_rsp_ready", mc_rsp_ready, 0);
    checkOutput("ar_orphan", rsp_orphan_err, 0);
    tick();
    mc_rsp_valid = 1'b0;
    rstn         = 1'b1;
    #1;
    checkOutput("ar_post_ready", ch_req_ready, 3'b001);
    checkOutput("ar_post_mc_valid", mc_req_valid, 0);
    tick();
    checkOutput("ar_post_pd", mc_req_pd, pdOf(0, 0));
    checkOutput("ar_post_valid", mc_req_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_part_rd_arb.md
NV_NVDLA_PART_RD_ARB -- requirements
Module: NV_NVDLA_part_rd_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of read-client channels (legal 2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have parameter RSP_W, default 65, response payload width (64 data + 1 mask).
REQ-004 SHALL have parameter TAG_DEPTH, default 8, maximum outstanding requests (power of 2, 2..32).
REQ-005 SHALL have port nvdla_core_clk, input, 1, sole clock.
REQ-006 SHALL have port nvdla_core_rstn, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port arb_mode, input, 1, 0 = round-robin, 1 = fixed priority (channel 0 highest).
REQ-008 SHALL have port ch_req_valid, input, NUM_CH, per-channel request valid.
REQ-009 SHALL have port ch_req_ready, output, NUM_CH, per-channel request accept.
REQ-010 SHALL have port ch_req_pd, input, NUM_CH*(ADDR_W+15): per channel [ADDR_W-1:0] address, [ADDR_W+14:ADDR_W] size (beats-1).
REQ-011 SHALL have ports mc_req_valid (output, 1), mc_req_ready (input, 1) and mc_req_pd (output, ADDR_W+15): merged request to MCIF.
REQ-012 SHALL have ports mc_rsp_valid (input, 1), mc_rsp_ready (output, 1) and mc_rsp_pd (input, RSP_W): MCIF response.
REQ-013 SHALL have ports ch_rsp_valid (output, NUM_CH), ch_rsp_ready (input, NUM_CH) and ch_rsp_pd (output, RSP_W, shared): routed responses.
REQ-014 SHALL have port ch_cdt_lat_fifo_pop, output, NUM_CH, one-cycle pulse per response beat accepted by a channel.
REQ-015 SHALL have port rsp_orphan_err, output, 1, sticky flag set by a response arriving with no outstanding tag.

Function
REQ-016 SHALL arbitrate only when the output stage is empty or mc_req_ready=1, and the tag FIFO is not full.
REQ-017 SHALL, in round-robin mode, grant the first valid channel after the last-granted one; the pointer updates only on an accepted grant.
REQ-018 SHALL, in fixed mode, grant the lowest-index valid channel; the RR pointer holds its value.
REQ-019 SHALL raise ch_req_ready only for the granted channel, in the same cycle as the grant; no other channel sees ready.
REQ-020 SHALL register the granted pd into the output stage; mc_req_valid asserts one cycle after the handshake (latency 1).
REQ-021 SHALL hold mc_req_valid/pd stable until mc_req_ready=1; back-to-back throughput is 1 request/cycle when ready stays high.
REQ-022 SHALL push {channel id, size} into the tag FIFO on each channel request handshake.
REQ-023 SHALL route responses combinationally: ch_rsp_valid[head_ch] = mc_rsp_valid & tag not empty; mc_rsp_ready = ch_rsp_ready[head_ch] & tag not empty.
REQ-024 SHALL count accepted beats for the head tag with a 15-bit counter and pop the tag and clear the counter on beat size+1.
REQ-025 SHALL allow a tag push and pop in the same cycle; occupancy stays unchanged and full/empty are computed from the pre-update count.
REQ-026 SHALL hold mc_rsp_ready=0 and set rsp_orphan_err when mc_rsp_valid=1 with the tag FIFO empty; rsp_orphan_err clears only on reset.
REQ-027 SHALL ignore arb_mode changes for the in-flight output stage; a change takes effect at the next arbitration.

Reset
REQ-028 SHALL, on reset, clear: all ch_req_ready, mc_req_valid, ch_rsp_valid, ch_cdt_lat_fifo_pop, rsp_orphan_err, tag FIFO pointers, beat counter; RR pointer = NUM_CH-1 (channel 0 wins first).
REQ-029 SHALL drop in-flight requests and tags on reset assertion mid-operation, with no output glitch after reset deassertion.

Structure
REQ-030 SHALL place the request-pd field offsets and the size width (15) in a shared package (NV_NVDLA_part_pkg).
REQ-031 SHALL implement the tag FIFO as one sub-module, NV_NVDLA_part_tag_fifo (flop-based, parametrised width/depth).

Verification
REQ-032 SHALL cover: RR mode, all 3 channels valid continuously, mc_req_ready=1 -> grants 0,1,2,0,1,2; mc_req_valid first high at cycle 1.
REQ-033 SHALL cover: fixed mode, ch0 and ch2 valid -> ch0 granted every cycle; ch2 granted only once ch0 deasserts.
REQ-034 SHALL cover: TAG_DEPTH=8, no responses -> 8 requests accepted, 9th stalls (ch_req_ready=0) until one tag pops.
REQ-035 SHALL cover: ch1 request size=3 then ch0 size=0, responses 5 beats -> 4 beats to ch1 then 1 to ch0; 5 cdt pop pulses total.
REQ-036 SHALL cover: mc_rsp_valid=1 with no outstanding tag -> mc_rsp_ready=0, rsp_orphan_err=1 held until reset.
REQ-037 SHALL cover: reset asserted with 3 tags outstanding -> all outputs 0 asynchronously; after release, first grant goes to channel 0.
